// File: rtl/mc_fetch_stage.sv
// Multicycle MIPS fetch/sequencing slice: PC, IR, MDR and ALUOut registers plus field decode.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module mc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcwrite,
  input  logic        branch,
  input  logic [1:0]  pcsrc,
  input  logic        irwrite,
  input  logic        iord,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sext,
  output logic [31:0] mdr,
  output logic [31:0] aluout,
  output logic        fetch_fault,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q;
  logic [31:0] mdr_q;
  logic [31:0] aluout_q;
  logic        fault_q, fault_d;
  logic        pcen;

  assign pcen = pcwrite | (branch & zero);

  always_comb begin
    pc_d = pc_q;
    if (pcen) begin
      case (pcsrc)
        2'b00:   pc_d = alu_result;
        2'b01:   pc_d = aluout_q;
        2'b10:   pc_d = {pc_q[31:28], instr_q[25:0], 2'b00};
        default: pc_d = pc_q;
      endcase
    end
  end

  // Only instruction fetches (iord=0) through a misaligned PC raise the sticky fault.
  assign fault_d = fault_q | (irwrite & ~iord & (pc_q[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      mdr_q    <= 32'h0;
      aluout_q <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      mdr_q    <= mem_rdata;
      aluout_q <= alu_result;
      fault_q  <= fault_d;
      if (irwrite) instr_q <= mem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_cnt_q, cycle_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt_q <= 32'h0;
      cycle_cnt_q <= 32'h0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (irwrite) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign instr_count = instr_cnt_q;
  assign cycle_count = cycle_cnt_q;
`else
  assign instr_count = 32'h0;
  assign cycle_count = 32'h0;
`endif

  assign mem_addr    = iord ? aluout_q : pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign mdr         = mdr_q;
  assign aluout      = aluout_q;
  assign fetch_fault = fault_q;

  assign op       = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign funct    = instr_q[5:0];
  assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};

endmodule

// File: tb/tb_mc_fetch_stage.sv
// Table-driven bench for mc_fetch_stage plus hand sequences for async reset and counters.
module tb_mc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcwrite = 1'b0, branch = 1'b0, irwrite = 1'b0, iord = 1'b0, zero = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] alu_result = 32'h0, mem_rdata = 32'h0;
  logic [31:0] mem_addr, pc, instr, imm_sext, mdr, aluout, instr_count, cycle_count;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  mc_fetch_stage dut (
    .clk(clk), .rst(rst), .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc),
    .irwrite(irwrite), .iord(iord), .zero(zero), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .pc(pc), .instr(instr), .op(op),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm_sext(imm_sext), .mdr(mdr),
    .aluout(aluout), .fetch_fault(fetch_fault), .instr_count(instr_count),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw, br, z, ir, io;
    logic [1:0]  src;
    logic [31:0] alu, mem;
    logic [31:0] e_pc, e_instr;
    logic        e_fault;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic br, input logic z, input logic ir,
                       input logic io, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] mem);
    pcwrite = pw; branch = br; zero = z; irwrite = ir; iord = io; pcsrc = src;
    alu_result = alu; mem_rdata = mem;
  endtask

  function automatic vec_t mk(input logic pw, input logic br, input logic z, input logic ir,
                              input logic io, input logic [1:0] src, input logic [31:0] alu,
                              input logic [31:0] mem, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic e_fault);
    vec_t v;
    v.pw = pw; v.br = br; v.z = z; v.ir = ir; v.io = io; v.src = src;
    v.alu = alu; v.mem = mem; v.e_pc = e_pc; v.e_instr = e_instr; v.e_fault = e_fault;
    return v;
  endfunction

  initial begin
    logic [31:0] ei, exp_addr;
    logic [31:0] exp_cnt_i, exp_cnt_c;

    //          pw br z  ir io src alu           mem           e_pc          e_instr      flt
    vecs[0]  = mk(1, 0, 0, 1, 0, 2'b00, 32'h4,        32'h20080005, 32'h4,        32'h20080005, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 2'b00, 32'h100,      32'h0,        32'h4,        32'h20080005, 0);
    vecs[2]  = mk(0, 1, 1, 0, 0, 2'b01, 32'h200,      32'h0,        32'h100,      32'h20080005, 0);
    vecs[3]  = mk(0, 1, 0, 0, 0, 2'b01, 32'h300,      32'h0,        32'h100,      32'h20080005, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 2'b00, 32'h2C,       32'h0,        32'h100,      32'h20080005, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 2'b11, 32'h44,       32'h0,        32'h100,      32'h20080005, 0);
    vecs[6]  = mk(1, 0, 0, 1, 0, 2'b00, 32'h80000010, 32'h08000004, 32'h80000010, 32'h08000004, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 2'b10, 32'h0,        32'h0,        32'h80000010, 32'h08000004, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 2'b00, 32'h0,        32'h0BFFFFFF, 32'h80000010, 32'h0BFFFFFF, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 2'b10, 32'hFFFFFFFC, 32'h0,        32'h8FFFFFFC, 32'h0BFFFFFF, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0BFFFFFF, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 2'b00, 32'h6,        32'h0,        32'h6,        32'h0BFFFFFF, 0);
    vecs[12] = mk(0, 0, 0, 1, 1, 2'b00, 32'h18,       32'h2108FFFC, 32'h6,        32'h2108FFFC, 0);
    vecs[13] = mk(0, 0, 0, 1, 0, 2'b00, 32'h20,       32'h012A4020, 32'h6,        32'h012A4020, 1);
    vecs[14] = mk(1, 0, 0, 1, 0, 2'b00, 32'h8,        32'h20080005, 32'h8,        32'h20080005, 1);
    vecs[15] = mk(0, 0, 0, 1, 0, 2'b00, 32'hC,        32'h2108FFFC, 32'h8,        32'h2108FFFC, 1);

    // Power-on reset, observed before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("por_pc", pc, 32'h0);
    check("por_instr", instr, 32'h0);
    check("por_op", {26'h0, op}, 32'h0);
    check("por_fault", {31'h0, fetch_fault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].pw, vecs[i].br, vecs[i].z, vecs[i].ir, vecs[i].io, vecs[i].src,
            vecs[i].alu, vecs[i].mem);
      @(posedge clk);
      @(negedge clk);
      ei       = vecs[i].e_instr;
      exp_addr = vecs[i].io ? vecs[i].alu : vecs[i].e_pc;
      check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("v%0d_instr", i), instr, ei);
      check($sformatf("v%0d_aluout", i), aluout, vecs[i].alu);
      check($sformatf("v%0d_mdr", i), mdr, vecs[i].mem);
      check($sformatf("v%0d_addr", i), mem_addr, exp_addr);
      check($sformatf("v%0d_fault", i), {31'h0, fetch_fault}, {31'h0, vecs[i].e_fault});
      check($sformatf("v%0d_op", i), {26'h0, op}, {26'h0, ei[31:26]});
      check($sformatf("v%0d_funct", i), {26'h0, funct}, {26'h0, ei[5:0]});
      check($sformatf("v%0d_rs", i), {27'h0, rs}, {27'h0, ei[25:21]});
      check($sformatf("v%0d_rt", i), {27'h0, rt}, {27'h0, ei[20:16]});
      check($sformatf("v%0d_rd", i), {27'h0, rd}, {27'h0, ei[15:11]});
      check($sformatf("v%0d_imm", i), imm_sext, {{16{ei[15]}}, ei[15:0]});
    end

    // Hand-computed decode of the first fetched word 0x20080005 (addi $t0,$zero,5).
    check("dec_op_addi", {26'h0, 6'h08}, {26'h0, vecs[0].e_instr[31:26]});
    // Combinational address mux: flip iord without a clock edge.
    iord = 1'b1;
    #1 check("mux_iord1", mem_addr, 32'hC);
    iord = 1'b0;
    #1 check("mux_iord0", mem_addr, 32'h8);

    // Mid-cycle asynchronous reset with pc=0x40 and a set fault flag.
    drive(1, 0, 0, 0, 0, 2'b00, 32'h40, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
    check("pre_rst_pc", pc, 32'h40);
    #2 rst = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_aluout", aluout, 32'h0);
    check("rst_fault", {31'h0, fetch_fault}, 32'h0);
    check("rst_funct", {26'h0, funct}, 32'h0);
    check("rst_icnt", instr_count, 32'h0);
    check("rst_ccnt", cycle_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Ten edges after release, three of them fetches.
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, (c == 0 || c == 4 || c == 8), 0, 2'b00, 32'h0, 32'h8C000000);
      @(posedge clk);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    exp_cnt_i = 32'd3;
    exp_cnt_c = 32'd10;
`else
    exp_cnt_i = 32'd0;
    exp_cnt_c = 32'd0;
`endif
    check("instr_count", instr_count, exp_cnt_i);
    check("cycle_count", cycle_count, exp_cnt_c);
    check("cnt_instr", instr, 32'h8C000000);
    check("cnt_fault", {31'h0, fetch_fault}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
